// File: rtl/left_collision_predictor.sv
// Left-paddle collision forecaster: traces a shadow ball from the live ball
// position to the paddle face, mirroring off the walls, and holds the result.
module left_collision_predictor #(
  parameter int X_TARGET  = 24,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 472,
  parameter int STEP      = 1,
  parameter int MAX_STEPS = 1023
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_ball_in_game,
  input  logic       i_ball_move_left,
  input  logic       i_ball_move_up,
  input  logic [9:0] i_ball_x,
  input  logic [9:0] i_ball_y,
  input  logic       i_left_paddle_collision,
  output logic       o_collision_predicted,
  output logic [9:0] o_collision_predicted_y,
  output logic       o_arrival_move_up,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [9:0]        X_T     = 10'(X_TARGET);
  localparam logic [9:0]        X_STOP  = 10'(X_TARGET + STEP);
  localparam logic [9:0]        X_STEP  = 10'(STEP);
  localparam logic [9:0]        CNT_MAX = 10'(MAX_STEPS);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX);
  localparam logic signed [10:0] Y_STEP = 11'(STEP);
  localparam logic [9:0]        REF_LO  = 10'(2 * Y_MIN + STEP);
  localparam logic [9:0]        REF_HI  = 10'(2 * Y_MAX - STEP);

  state_t state, state_nx;

  logic [9:0] trace_x, trace_y, step_cnt;
  logic       trace_up;

  logic abort, trigger;
  logic load, step, arrive, expire;

  logic signed [10:0] y_cur, y_up, y_dn;
  logic [9:0]         x_nx, y_nx;
  logic               up_nx;

  assign abort   = ~i_ball_in_game | ~i_ball_move_left | i_left_paddle_collision;
  assign trigger = i_ball_in_game & i_ball_move_left & ~i_left_paddle_collision &
                   (i_ball_x > X_T);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    arrive   = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nx = TRACE;
          load     = 1'b1;
        end
      end
      TRACE: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (trace_x == X_T) begin
          state_nx = VALID;
          arrive   = 1'b1;
        end else if (step_cnt == CNT_MAX) begin
          state_nx = IDLE;
          expire   = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      VALID: begin
        if (abort) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Wall reflection: the signed 11-bit probes detect overshoot, while the
  // mirrored position is formed in 10 bits since it always lands in range.
  always_comb begin
    y_cur = signed'({1'b0, trace_y});
    y_up  = y_cur - Y_STEP;
    y_dn  = y_cur + Y_STEP;
    y_nx  = trace_y;
    up_nx = trace_up;
    if (trace_up) begin
      if (y_up >= Y_LO) begin
        y_nx = y_up[9:0];
      end else begin
        y_nx  = REF_LO - trace_y;
        up_nx = 1'b0;
      end
    end else begin
      if (y_dn <= Y_HI) begin
        y_nx = y_dn[9:0];
      end else begin
        y_nx  = REF_HI - trace_y;
        up_nx = 1'b1;
      end
    end
    x_nx = (trace_x < X_STOP) ? X_T : (trace_x - X_STEP);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      trace_x                <= '0;
      trace_y                <= '0;
      trace_up               <= 1'b0;
      step_cnt               <= '0;
      o_collision_predicted_y <= '0;
      o_arrival_move_up      <= 1'b0;
      o_timeout              <= 1'b0;
    end else begin
      o_timeout <= expire;
      if (load) begin
        trace_x  <= i_ball_x;
        trace_y  <= i_ball_y;
        trace_up <= i_ball_move_up;
        step_cnt <= '0;
      end else if (step) begin
        trace_x  <= x_nx;
        trace_y  <= y_nx;
        trace_up <= up_nx;
        step_cnt <= step_cnt + 10'd1;
      end
      if (arrive) begin
        o_collision_predicted_y <= trace_y;
        o_arrival_move_up      <= trace_up;
      end
    end
  end

  assign o_collision_predicted = (state == VALID);
  assign o_busy                = (state == TRACE);

endmodule

// File: tb/tb_left_collision_predictor.sv
// Bench for left_collision_predictor: closed-form reflection model plus
// directed scenarios with hand-computed expectations and a random soak.
module tb_left_collision_predictor;

  localparam int X_T   = 20;
  localparam int Y_LO  = 0;
  localparam int Y_HI  = 472;
  localparam int STP   = 1;
  localparam int MAXS  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_game = 1'b0, move_left = 1'b0, move_up = 1'b0, coll = 1'b0;
  logic [9:0] bx = '0, by = '0;
  logic       pred, arr_up, busy, tmo;
  logic [9:0] pred_y;

  int checks = 0;
  int failures = 0;

  left_collision_predictor #(
    .X_TARGET(X_T), .Y_MIN(Y_LO), .Y_MAX(Y_HI), .STEP(STP), .MAX_STEPS(MAXS)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_ball_in_game(in_game), .i_ball_move_left(move_left),
    .i_ball_move_up(move_up), .i_ball_x(bx), .i_ball_y(by),
    .i_left_paddle_collision(coll),
    .o_collision_predicted(pred), .o_collision_predicted_y(pred_y),
    .o_arrival_move_up(arr_up), .o_busy(busy), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  // Outcome of a full trace, computed by unfolding the bounces: the shadow
  // moves linearly in an unbounded coordinate folded with period 2*(Y_HI-Y_LO).
  function automatic void predict(input int x0, input int y0, input bit up0,
                                  output int n, output int yr, output bit upr);
    int span, u, m;
    span = Y_HI - Y_LO;
    n = (x0 - X_T + STP - 1) / STP;
    u = up0 ? (y0 - Y_LO) - n * STP : (y0 - Y_LO) + n * STP;
    m = ((u % (2 * span)) + 2 * span) % (2 * span);
    yr  = (m <= span) ? Y_LO + m : Y_LO + 2 * span - m;
    upr = up0 ? (m < span) : !(m > 0 && m <= span);
  endfunction

  // Model: 0 idle, 1 tracing (countdown to resolution), 2 prediction held.
  int m_phase = 0, m_left = 0, m_y = 0, m_ry = 0;
  bit m_up = 0, m_rup = 0, m_to = 0, m_expire = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_y = 0; m_up = 0; m_to = 0;
    end else begin
      int n, ry;
      bit rup, ab;
      ab = !in_game || !move_left || coll;
      m_to = 0;
      case (m_phase)
        0: if (!ab && int'(bx) > X_T) begin
             predict(int'(bx), int'(by), move_up, n, ry, rup);
             m_expire = n > MAXS;
             m_left = m_expire ? MAXS : n;
             m_ry = ry; m_rup = rup;
             m_phase = 1;
           end
        1: if (ab) m_phase = 0;
           else if (m_left == 0) begin
             if (m_expire) begin m_phase = 0; m_to = 1; end
             else begin m_phase = 2; m_y = m_ry; m_up = m_rup; end
           end else m_left--;
        default: if (ab) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if (pred !== (m_phase == 2) || busy !== (m_phase == 1) || tmo !== m_to ||
        int'(pred_y) != m_y || arr_up !== m_up) begin
      failures++;
      $display("FAIL cycle t=%0t got pred=%0b busy=%0b to=%0b y=%0d up=%0b exp pred=%0b busy=%0b to=%0b y=%0d up=%0b",
               $time, pred, busy, tmo, pred_y, arr_up,
               m_phase == 2, m_phase == 1, m_to, m_y, m_up);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit g, input bit l, input bit u, input bit c,
                       input int x, input int y);
    in_game = g; move_left = l; move_up = u; coll = c;
    bx = 10'(x); by = 10'(y);
  endtask

  task automatic go_idle();
    @(negedge clk); #1 drive(0, 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
  endtask

  // Returns at the trigger edge E.
  task automatic launch(input int x, input int y, input bit up);
    @(negedge clk); #1 drive(1, 1, up, 0, x, y);
    @(posedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_pred", int'(pred), 0);
    chk("reset_y", int'(pred_y), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk); #1 rst = 1'b0;

    launch(100, 200, 1);
    repeat (80) @(posedge clk);
    #1 chk("nowall_busy_e80", int'(busy), 1);
    chk("nowall_pred_e80", int'(pred), 0);
    @(posedge clk);
    #1 chk("nowall_pred_e81", int'(pred), 1);
    chk("nowall_y", int'(pred_y), 120);
    chk("nowall_up", int'(arr_up), 1);
    repeat (5) @(posedge clk);
    #1 chk("valid_held", int'(pred), 1);
    go_idle();

    launch(100, 10, 1);
    repeat (81) @(posedge clk);
    #1 chk("top_y", int'(pred_y), 70);
    chk("top_up", int'(arr_up), 0);
    go_idle();

    launch(100, 460, 0);
    repeat (81) @(posedge clk);
    #1 chk("bottom_y", int'(pred_y), 404);
    chk("bottom_up", int'(arr_up), 1);
    go_idle();

    launch(21, 0, 1);
    repeat (2) @(posedge clk);
    #1 chk("onestep_y", int'(pred_y), 1);
    chk("onestep_up", int'(arr_up), 0);
    go_idle();

    launch(100, 200, 1);
    repeat (40) @(posedge clk);
    #1 move_left = 1'b0;
    @(posedge clk);
    #1 chk("abort_trace_busy", int'(busy), 0);
    repeat (50) @(posedge clk);
    #1 chk("abort_trace_pred", int'(pred), 0);
    go_idle();

    launch(100, 200, 1);
    repeat (81) @(posedge clk);
    #1 chk("abort_valid_pre", int'(pred), 1);
    coll = 1'b1;
    @(posedge clk);
    #1 chk("abort_valid_post", int'(pred), 0);
    go_idle();

    launch(120, 200, 1);
    repeat (101) @(posedge clk);
    #1 chk("budget_edge_pred", int'(pred), 1);
    chk("budget_edge_to", int'(tmo), 0);
    chk("budget_edge_y", int'(pred_y), 100);
    go_idle();

    launch(200, 200, 1);
    repeat (100) @(posedge clk);
    #1 chk("timeout_pre", int'(tmo), 0);
    @(posedge clk);
    #1 chk("timeout_pulse", int'(tmo), 1);
    chk("timeout_busy", int'(busy), 0);
    @(posedge clk);
    #1 chk("timeout_end", int'(tmo), 0);
    chk("timeout_pred", int'(pred), 0);
    go_idle();

    @(negedge clk); #1 drive(1, 1, 1, 0, X_T, 200);
    repeat (5) @(posedge clk);
    #1 chk("no_trigger_busy", int'(busy), 0);
    go_idle();

    launch(100, 200, 1);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_busy", int'(busy), 0);
    chk("rst_pred", int'(pred), 0);
    chk("rst_y", int'(pred_y), 0);
    chk("rst_up", int'(arr_up), 0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk);
    repeat (81) @(posedge clk);
    #1 chk("rst_retrace_pred", int'(pred), 1);
    chk("rst_retrace_y", int'(pred_y), 120);

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 2999) == 0) rst = 1'b1;
      in_game   = ($urandom_range(0, 299) != 0);
      move_left = ($urandom_range(0, 199) != 0);
      coll      = ($urandom_range(0, 299) == 0);
      move_up   = 1'($urandom_range(0, 1));
      bx        = 10'($urandom_range(0, 260));
      by        = 10'($urandom_range(Y_LO, Y_HI));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
